// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_unit
// Description : Hazard controller for the 5-stage pipeline. Detects load-use
//               hazards and stalls the front end for MEM_LAT cycles, flushes
//               IF/ID, ID/EX and EX/MEM on a taken branch, and produces the EX
//               operand forwarding selects.
//
//               Optional feature macro: HAZARD_PERF_EN
//                 defined   -> stall_cnt / flush_cnt saturating counters
//                 undefined -> no counter flops, both outputs tied to zero
//
// Ports       : clk, rst (async, active-high)
//               id_rs/id_rt/id_uses_rs/id_uses_rt  - ID-stage sources
//               ex_memread/ex_rt/ex_rs              - EX-stage load + sources
//               mem_regwrite/mem_rd, wb_regwrite/wb_rd - forwarding producers
//               branch_taken                        - taken branch from MEM
//               pc_write/if_id_write/id_ex_bubble   - stall controls
//               flush_if_id/flush_id_ex/flush_ex_mem - flush controls
//               fwd_a/fwd_b                         - 00 RF, 10 EX/MEM, 01 MEM/WB
//               stall_cnt/flush_cnt                 - performance counters
//
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl_unit #(
    parameter int REG_AW  = 5,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              wb_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              branch_taken,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              id_ex_bubble,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              flush_ex_mem,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // Latency counter is sized for the full 1..15 range of MEM_LAT.
    localparam logic [3:0] c_LAT_INIT = 4'(MEM_LAT - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_STALL = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_lat_cnt;
    logic [3:0]  w_lat_cnt_nxt;
    logic        w_load_use;

    assign w_load_use = ex_memread && (ex_rt != '0) &&
                        ((id_uses_rs && (id_rs == ex_rt)) ||
                         (id_uses_rt && (id_rt == ex_rt)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_lat_cnt <= 4'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_lat_cnt <= w_lat_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_lat_cnt_nxt = r_lat_cnt;
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_bubble  = 1'b0;
        flush_if_id   = 1'b0;
        flush_id_ex   = 1'b0;
        flush_ex_mem  = 1'b0;

        if (branch_taken) begin
            // A taken branch overrides everything, including a stall in flight.
            flush_if_id   = 1'b1;
            flush_id_ex   = 1'b1;
            flush_ex_mem  = 1'b1;
            w_state_nxt   = S_IDLE;
            w_lat_cnt_nxt = 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_load_use) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        // The detect cycle itself is the first stall cycle;
                        // STALL covers the remaining MEM_LAT-1.
                        if (MEM_LAT > 1) begin
                            w_state_nxt   = S_STALL;
                            w_lat_cnt_nxt = c_LAT_INIT;
                        end
                    end
                end
                S_STALL: begin
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    id_ex_bubble  = 1'b1;
                    w_lat_cnt_nxt = r_lat_cnt - 4'd1;
                    if (r_lat_cnt == 4'd1) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt   = S_IDLE;
                    w_lat_cnt_nxt = 4'd0;
                end
            endcase
        end
    end

    // Forwarding: EX/MEM has priority over MEM/WB; r0 is never forwarded.
    always_comb begin
        fwd_a = 2'b00;
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs)) begin
            fwd_a = 2'b10;
        end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs)) begin
            fwd_a = 2'b01;
        end
    end

    always_comb begin
        fwd_b = 2'b00;
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rt)) begin
            fwd_b = 2'b10;
        end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rt)) begin
            fwd_b = 2'b01;
        end
    end

`ifdef HAZARD_PERF_EN
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Both counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!pc_write && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            end
            if (branch_taken && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl_unit
// Description : Self-checking bench for hazard_ctrl_unit. A cycle-level
//               reference model (remaining-stall count plus event totals)
//               predicts every output; directed sequences cover the main
//               scenarios, then randomized traffic runs against the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl_unit;

    localparam int REG_AW  = 5;
    localparam int MEM_LAT = 3;
    localparam int CNT_W   = 4;
    localparam longint c_CNT_MAX = (64'd1 << CNT_W) - 1;

    logic              clk;
    logic              rst;
    logic [REG_AW-1:0] id_rs, id_rt, ex_rt, ex_rs, mem_rd, wb_rd;
    logic              id_uses_rs, id_uses_rt, ex_memread;
    logic              mem_regwrite, wb_regwrite, branch_taken;
    logic              pc_write, if_id_write, id_ex_bubble;
    logic              flush_if_id, flush_id_ex, flush_ex_mem;
    logic [1:0]        fwd_a, fwd_b;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    int     n_checks;
    int     n_fails;

    // Reference model state
    int     m_rem;      // stall cycles still owed after the current one
    longint m_stall;    // stall cycles seen so far
    longint m_flush;    // branch cycles seen so far

    hazard_ctrl_unit #(
        .REG_AW (REG_AW),
        .MEM_LAT(MEM_LAT),
        .CNT_W  (CNT_W)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rs  (id_uses_rs),
        .id_uses_rt  (id_uses_rt),
        .ex_memread  (ex_memread),
        .ex_rt       (ex_rt),
        .ex_rs       (ex_rs),
        .mem_regwrite(mem_regwrite),
        .mem_rd      (mem_rd),
        .wb_regwrite (wb_regwrite),
        .wb_rd       (wb_rd),
        .branch_taken(branch_taken),
        .pc_write    (pc_write),
        .if_id_write (if_id_write),
        .id_ex_bubble(id_ex_bubble),
        .flush_if_id (flush_if_id),
        .flush_id_ex (flush_id_ex),
        .flush_ex_mem(flush_ex_mem),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwd_ref(input logic [REG_AW-1:0] src);
        if (mem_regwrite && mem_rd != 0 && mem_rd == src) return 2'b10;
        if (wb_regwrite && wb_rd != 0 && wb_rd == src)    return 2'b01;
        return 2'b00;
    endfunction

    task automatic idle_inputs();
        id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        ex_memread = 1'b0; ex_rt = '0; ex_rs = '0;
        mem_regwrite = 1'b0; mem_rd = '0; wb_regwrite = 1'b0; wb_rd = '0;
        branch_taken = 1'b0;
    endtask

    task automatic model_reset();
        m_rem   = 0;
        m_stall = 0;
        m_flush = 0;
    endtask

    // Inputs are applied just after a rising edge; this checks at the
    // falling edge, advances the model and returns just after the next edge.
    task automatic cycle();
        bit     det, stall;
        int     rem_nxt;
        longint e_sc, e_fc;
        @(negedge clk);
        det = ex_memread && ex_rt != 0 &&
              ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
        stall   = 1'b0;
        rem_nxt = m_rem;
        if (branch_taken) begin
            rem_nxt = 0;
        end else if (m_rem > 0) begin
            stall   = 1'b1;
            rem_nxt = m_rem - 1;
        end else if (det) begin
            stall   = 1'b1;
            rem_nxt = MEM_LAT - 1;
        end
`ifdef HAZARD_PERF_EN
        e_sc = m_stall;
        e_fc = m_flush;
`else
        e_sc = 0;
        e_fc = 0;
`endif
        chk("pc_write",     32'(pc_write),     32'(!stall));
        chk("if_id_write",  32'(if_id_write),  32'(!stall));
        chk("id_ex_bubble", 32'(id_ex_bubble), 32'(stall));
        chk("flush_if_id",  32'(flush_if_id),  32'(branch_taken));
        chk("flush_id_ex",  32'(flush_id_ex),  32'(branch_taken));
        chk("flush_ex_mem", 32'(flush_ex_mem), 32'(branch_taken));
        chk("fwd_a",        32'(fwd_a),        32'(fwd_ref(ex_rs)));
        chk("fwd_b",        32'(fwd_b),        32'(fwd_ref(ex_rt)));
        chk("stall_cnt",    32'(stall_cnt),    32'(e_sc));
        chk("flush_cnt",    32'(flush_cnt),    32'(e_fc));
        if (stall && m_stall < c_CNT_MAX)        m_stall++;
        if (branch_taken && m_flush < c_CNT_MAX) m_flush++;
        m_rem = rem_nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic load_use_hazard();
        idle_inputs();
        ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        model_reset();
        idle_inputs();
        rst = 1'b1;
        #12;
        // Reset state, checked while reset is still asserted.
        chk("rst_pc_write", 32'(pc_write), 32'd1);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle outputs
        for (int i = 0; i < 2; i++) cycle();

        // Load-use hazard held for one cycle: MEM_LAT stall cycles follow.
        load_use_hazard();
        cycle();
        idle_inputs();
        for (int i = 0; i < MEM_LAT + 2; i++) cycle();

        // Hazard via rt, then a branch in the second stall cycle aborts it.
        idle_inputs();
        ex_memread = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1;
        cycle();
        idle_inputs();
        branch_taken = 1'b1;
        cycle();
        branch_taken = 1'b0;
        for (int i = 0; i < 3; i++) cycle();

        // Load into r0 never stalls; matching register but unused source either.
        idle_inputs();
        ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
        cycle();
        idle_inputs();
        ex_memread = 1'b1; ex_rt = 5'd4; id_rs = 5'd4; id_uses_rs = 1'b0;
        cycle();

        // Forwarding priority and the r0 exclusion.
        idle_inputs();
        ex_rs = 5'd7; mem_rd = 5'd7; wb_rd = 5'd7;
        mem_regwrite = 1'b1; wb_regwrite = 1'b1;
        #1 chk("fwd_a_exmem", 32'(fwd_a), 32'd2);
        cycle();
        mem_regwrite = 1'b0;
        #1 chk("fwd_a_memwb", 32'(fwd_a), 32'd1);
        cycle();
        ex_rs = 5'd0; mem_rd = 5'd0; mem_regwrite = 1'b1; wb_rd = 5'd0;
        #1 chk("fwd_a_r0", 32'(fwd_a), 32'd0);
        cycle();
        ex_rt = 5'd3; mem_rd = 5'd3; wb_rd = 5'd3;
        cycle();

        // Reset in the middle of a stall returns enables immediately.
        load_use_hazard();
        cycle();
        idle_inputs();
        #1 chk("mid_stall_pc_write", 32'(pc_write), 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_async_pc_write",    32'(pc_write),     32'd1);
        chk("rst_async_if_id_write", 32'(if_id_write),  32'd1);
        chk("rst_async_bubble",      32'(id_ex_bubble), 32'd0);
        chk("rst_async_stall_cnt",   32'(stall_cnt),    32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 2; i++) cycle();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            id_rs        = REG_AW'($urandom_range(0, 3));
            id_rt        = REG_AW'($urandom_range(0, 3));
            id_uses_rs   = 1'($urandom);
            id_uses_rt   = 1'($urandom);
            ex_memread   = 1'($urandom);
            ex_rt        = REG_AW'($urandom_range(0, 3));
            ex_rs        = REG_AW'($urandom_range(0, 3));
            mem_regwrite = 1'($urandom);
            mem_rd       = REG_AW'($urandom_range(0, 3));
            wb_regwrite  = 1'($urandom);
            wb_rd        = REG_AW'($urandom_range(0, 3));
            branch_taken = ($urandom_range(0, 7) == 0);
            cycle();
        end

        // Flush counter saturation with a long branch burst.
        do_reset();
        branch_taken = 1'b1;
        for (int i = 0; i < 20; i++) cycle();
        idle_inputs();
        cycle();
`ifdef HAZARD_PERF_EN
        chk("flush_cnt_sat", 32'(flush_cnt), 32'd15);
`else
        chk("flush_cnt_off", 32'(flush_cnt), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Parametrised hazard controller for the 5-stage pipeline: load-use stall, taken-branch flush and EX operand forwarding selects.
- Sits beside the stage modules at pipeline top level.
- Drives PC/IF-ID write enables, ID/EX bubble, per-stage flushes and ALU operand mux selects.
- Adds multi-cycle load latency and optional performance counters.

Parameters:
- REG_AW, 5, register address width.
- MEM_LAT, 1, load-use stall cycles per detected hazard (1..15).
- CNT_W, 32, width of performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- id_rs  in  REG_AW  rs of instruction in ID.
- id_rt  in  REG_AW  rt of instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_memread  in  1  instruction in EX is a load.
- ex_rt  in  REG_AW  load destination (rt) in EX; also EX source B.
- ex_rs  in  REG_AW  EX source A.
- mem_regwrite  in  1  EX/MEM RegWrite.
- mem_rd  in  REG_AW  EX/MEM destination.
- wb_regwrite  in  1  MEM/WB RegWrite.
- wb_rd  in  REG_AW  MEM/WB destination.
- branch_taken  in  1  PCSrc from MEM stage.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID update enable.
- id_ex_bubble  out  1  force ID/EX control fields to zero.
- flush_if_id  out  1  clear IF/ID.
- flush_id_ex  out  1  clear ID/EX.
- flush_ex_mem  out  1  clear EX/MEM control.
- fwd_a  out  2  EX operand A select: 00 regfile, 10 EX/MEM, 01 MEM/WB.
- fwd_b  out  2  EX operand B select, same encoding.
- stall_cnt  out  CNT_W  total stall cycles.
- flush_cnt  out  CNT_W  total taken-branch flushes.

Behaviour:
- Reset (async, immediate): state IDLE, lat_cnt 0, counters 0.
- Outputs with all inputs 0: pc_write=1, if_id_write=1, all others 0.
- Load-use detect (comb): ex_memread && ex_rt!=0 && ((id_uses_rs && id_rs==ex_rt) || (id_uses_rt && id_rt==ex_rt)).
- FSM states: IDLE, STALL.
- IDLE, detect=1, branch_taken=0:
  - Same cycle: pc_write=0, if_id_write=0, id_ex_bubble=1.
  - If MEM_LAT>1: next state STALL, lat_cnt=MEM_LAT-1.
  - If MEM_LAT==1: stay IDLE.
- STALL: pc_write=0, if_id_write=0, id_ex_bubble=1.
  - lat_cnt decrements each cycle.
  - Leaves to IDLE in the cycle lat_cnt==1.
  - Total stall for one hazard = MEM_LAT cycles.
  - Detect is not re-evaluated in STALL. Re-evaluated in the first IDLE cycle after.
- branch_taken (highest priority, any state):
  - Same cycle: flush_if_id=flush_id_ex=flush_ex_mem=1, pc_write=1, if_id_write=1, id_ex_bubble=0.
  - FSM forced to IDLE next cycle, lat_cnt cleared.
  - Aborts an in-progress stall.
- branch_taken held N consecutive cycles -> flushes N cycles, flush_cnt +N.
- Forwarding (comb, independent of FSM):
  - fwd_a=10 if mem_regwrite && mem_rd!=0 && mem_rd==ex_rs.
  - else 01 if wb_regwrite && wb_rd!=0 && wb_rd==ex_rs.
  - else 00.
  - fwd_b identical against ex_rt.
  - EX/MEM beats MEM/WB on simultaneous match.
  - Register 0 never forwarded.
- Counters:
  - stall_cnt +1 every cycle pc_write==0.
  - flush_cnt +1 every cycle branch_taken==1.
  - Both saturate at all-ones, no wrap.
- Reset mid-stall: immediate IDLE, enables return to 1 asynchronously.

Optional Feature:
- HAZARD_PERF_EN defined: stall_cnt/flush_cnt registers implemented as above.
- Undefined: no counter flops; stall_cnt and flush_cnt tied to 0; all other behaviour identical.

Test Plan:
- Reset then idle inputs -> pc_write=1, if_id_write=1, fwd_a=fwd_b=00, flushes 0, counters 0.
- MEM_LAT=1: ex_memread=1, ex_rt=5, id_rs=5, id_uses_rs=1 for one cycle -> exactly 1 cycle pc_write=0/id_ex_bubble=1; stall_cnt=1.
- MEM_LAT=3, same hazard -> 3 consecutive stall cycles, then enables 1; stall_cnt=3.
- MEM_LAT=3: hazard, then branch_taken=1 in 2nd stall cycle -> flushes all 1, pc_write=1 that cycle, IDLE next; stall_cnt=1, flush_cnt=1.
- Forwarding: ex_rs=7, mem_rd=7, wb_rd=7, both regwrite -> fwd_a=10. Then mem_regwrite=0 -> 01. Then ex_rs=0 with mem_rd=0 -> 00.
- CNT_W=4, HAZARD_PERF_EN: 20 cycles branch_taken=1 -> flush_cnt=15 held. Macro undefined -> flush_cnt=0 throughout.
